// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul operand loader, core and bench.
package matmul_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int M          = 32;
    localparam int DIM_W      = $clog2(M) + 1;
    localparam int AW         = $clog2(M);

    typedef logic signed [DATA_WIDTH-1:0] element_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_RUN
    } state_t;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(M));
    endfunction
endpackage

// File: rtl/matmul_opbuf.sv
// Single M x M operand store: one write port, one registered read port.
module matmul_opbuf
    import matmul_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_row,
    input  logic [AW-1:0] i_wr_col,
    input  element_t      i_wr_data,
    input  logic [AW-1:0] i_rd_row,
    input  logic [AW-1:0] i_rd_col,
    output element_t      o_rd_data
);
    element_t r_mem [M*M];
    element_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_row, i_wr_col}] <= i_wr_data;
        end
    end

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{i_rd_row, i_rd_col}];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/matmul_loader.sv
// Operand loader: descriptor, row-major A then B stream, start handshake, frozen buffers until core_done.
// Optional MATMUL_LOADER_ZERO_PAD_EN: reads outside the latched dims return 0.
module matmul_loader
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic [DIM_W-1:0] cfg_cols2,
    input  logic             in_valid,
    output logic             in_ready,
    input  element_t         in_data,
    input  logic             in_last,
    output logic             start_valid,
    input  logic             start_ready,
    input  logic             core_done,
    input  logic             rd_mat,
    input  logic [AW-1:0]    rd_row,
    input  logic [AW-1:0]    rd_col,
    output element_t         rd_data,
    output logic [DIM_W-1:0] dims_rows,
    output logic [DIM_W-1:0] dims_cols,
    output logic [DIM_W-1:0] dims_cols2,
    output logic             err
);
    state_t           r_state;
    logic [AW-1:0]    r_row, r_col;
    logic [DIM_W-1:0] r_rows, r_cols, r_cols2;
    logic             r_cfg_ready, r_in_ready, r_start_valid, r_err;
    logic             r_rd_mat_q, r_pad_q;

    logic             w_beat, w_col_end, w_row_end, w_final, w_bad_last;
    logic             w_wr_a, w_wr_b, w_oob;
    logic [DIM_W-1:0] w_row_lim, w_col_lim;
    element_t         w_a_q, w_b_q;

    // The walk limits switch from rows x cols (A) to cols x cols2 (B).
    assign w_row_lim  = (r_state == ST_LOAD_A) ? r_rows : r_cols;
    assign w_col_lim  = (r_state == ST_LOAD_A) ? r_cols : r_cols2;
    assign w_col_end  = ({1'b0, r_col} == w_col_lim - DIM_W'(1));
    assign w_row_end  = ({1'b0, r_row} == w_row_lim - DIM_W'(1));
    assign w_final    = w_col_end && w_row_end;
    assign w_beat     = in_valid && r_in_ready;
    assign w_bad_last = (r_state == ST_LOAD_A) ? in_last : (in_last != w_final);
    assign w_wr_a     = w_beat && (r_state == ST_LOAD_A);
    assign w_wr_b     = w_beat && (r_state == ST_LOAD_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_cols2       <= '0;
            r_cfg_ready   <= 1'b1;
            r_in_ready    <= 1'b0;
            r_start_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (dim_ok(cfg_rows) && dim_ok(cfg_cols) && dim_ok(cfg_cols2)) begin
                            r_rows      <= cfg_rows;
                            r_cols      <= cfg_cols;
                            r_cols2     <= cfg_cols2;
                            r_row       <= '0;
                            r_col       <= '0;
                            r_state     <= ST_LOAD_A;
                            r_cfg_ready <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (w_beat) begin
                        if (w_bad_last) begin
                            r_err       <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_in_ready  <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end else if (w_final) begin
                            r_row <= '0;
                            r_col <= '0;
                            if (r_state == ST_LOAD_A) begin
                                r_state <= ST_LOAD_B;
                            end else begin
                                r_state       <= ST_START;
                                r_in_ready    <= 1'b0;
                                r_start_valid <= 1'b1;
                            end
                        end else if (w_col_end) begin
                            r_col <= '0;
                            r_row <= r_row + AW'(1);
                        end else begin
                            r_col <= r_col + AW'(1);
                        end
                    end
                end
                ST_START: begin
                    if (start_ready) begin
                        r_state       <= ST_RUN;
                        r_start_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cfg_ready   <= 1'b1;
                    r_in_ready    <= 1'b0;
                    r_start_valid <= 1'b0;
                end
            endcase
        end
    end

    matmul_opbuf u_buf_a (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_a),
        .i_wr_row  (r_row),
        .i_wr_col  (r_col),
        .i_wr_data (in_data),
        .i_rd_row  (rd_row),
        .i_rd_col  (rd_col),
        .o_rd_data (w_a_q)
    );

    matmul_opbuf u_buf_b (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_b),
        .i_wr_row  (r_row),
        .i_wr_col  (r_col),
        .i_wr_data (in_data),
        .i_rd_row  (rd_row),
        .i_rd_col  (rd_col),
        .o_rd_data (w_b_q)
    );

`ifdef MATMUL_LOADER_ZERO_PAD_EN
    assign w_oob = rd_mat ? (({1'b0, rd_row} >= r_cols) || ({1'b0, rd_col} >= r_cols2))
                          : (({1'b0, rd_row} >= r_rows) || ({1'b0, rd_col} >= r_cols));
`else
    assign w_oob = 1'b0;
`endif

    // Matrix select and pad flag are delayed to line up with the buffer read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_mat_q <= 1'b0;
            r_pad_q    <= 1'b0;
        end else begin
            r_rd_mat_q <= rd_mat;
            r_pad_q    <= w_oob;
        end
    end

    assign rd_data     = r_pad_q ? '0 : (r_rd_mat_q ? w_b_q : w_a_q);
    assign cfg_ready   = r_cfg_ready;
    assign in_ready    = r_in_ready;
    assign start_valid = r_start_valid;
    assign err         = r_err;
    assign dims_rows   = r_rows;
    assign dims_cols   = r_cols;
    assign dims_cols2  = r_cols2;
endmodule
